// File: rtl/mmv_guard_pkg.sv
// rtl/mmv_guard_pkg.sv - shared state type, fault counter width and saturating add for mmv_guard
package mmv_guard_pkg;

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_ISOLATED = 2'd2
   } guard_state_t;

   localparam int FAULT_W = 16;

   // Adds 0..2 faults to a counter, sticking at all ones instead of wrapping
   function automatic logic [FAULT_W-1:0] sat_add(input logic [FAULT_W-1:0] cnt,
                                                  input logic [1:0]         inc);
      logic [FAULT_W:0] sum;
      sum = {1'b0, cnt} + {{(FAULT_W - 1){1'b0}}, inc};
      return sum[FAULT_W] ? {FAULT_W{1'b1}} : sum[FAULT_W-1:0];
   endfunction

endpackage

// File: rtl/mmv_guard_fifo.sv
// rtl/mmv_guard_fifo.sv - show-ahead timestamp FIFO for in-order pending reads
module mmv_guard_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full blocks push even when a pop happens in the same cycle
   assign do_push   = push & ~full;
   assign do_pop    = pop & ~empty;
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; an extra wrap bit tells full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write, no reset needed since empty masks stale entries
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mmv_guard.sv
// rtl/mmv_guard.sv - busy/read-timeout guard for an untrusted slave; isolation FSM under MMV_GUARD_ISOLATE_EN
module mmv_guard
   import mmv_guard_pkg::*;
#(
   parameter int                AWIDTH    = 8,
   parameter int                DWIDTH    = 8,
   parameter int                MAXPENDRD = 8,
   parameter int                TWIDTH    = 8,
   parameter int                ISOLTHR   = 4,
   parameter logic [DWIDTH-1:0] ERRRDVAL  = {DWIDTH{1'b1}}
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [AWIDTH-1:0]  s_addr,
   input  logic               s_wreq,
   input  logic [DWIDTH-1:0]  s_wdat,
   input  logic               s_rreq,
   output logic [DWIDTH-1:0]  s_rdat,
   output logic               s_rval,
   output logic               s_busy,
   output logic [AWIDTH-1:0]  m_addr,
   output logic               m_wreq,
   output logic [DWIDTH-1:0]  m_wdat,
   output logic               m_rreq,
   input  logic [DWIDTH-1:0]  m_rdat,
   input  logic               m_rval,
   input  logic               m_busy,
   input  logic [TWIDTH-1:0]  cfg_busy_tmo,
   input  logic [TWIDTH-1:0]  cfg_rval_tmo,
   input  logic               clr,
   output logic               busy_timeout,
   output logic               rval_timeout,
   output logic               rval_is_odd,
   output logic [FAULT_W-1:0] fault_cnt,
   output logic               isolated
);

   logic [TWIDTH-1:0] now;
   logic [TWIDTH-1:0] head_ts;
   logic [TWIDTH-1:0] age;
   logic [TWIDTH-1:0] rval_tmo_eff;
   logic [TWIDTH-1:0] busy_cnt;
   logic [TWIDTH:0]   busy_cnt_inc;
   logic              fifo_empty;
   logic              fifo_full;
   logic              rel_q;
   logic              fwd_en;
   logic              drain;
   logic              iso;
   logic              push;
   logic              pop;
   logic              forced;
   logic              odd_rval;
   logic              iso_rd;
   logic              busy_cycle;
   logic              busy_hit;
   logic [1:0]        fault_inc;

   assign m_addr = s_addr;
   assign m_wdat = s_wdat;

   // Requests only reach the slave in NORMAL and while a pending slot is free
   assign m_wreq = s_wreq & ~fifo_full & fwd_en;
   assign m_rreq = s_rreq & ~fifo_full & fwd_en;
   assign s_busy = drain | (fwd_en & ((m_busy & ~rel_q) | fifo_full));

   assign push     = s_rreq & ~s_busy & fwd_en;
   assign iso_rd   = iso & s_rreq;

   // Age is modulo 2^TWIDTH so the free-running stamp may wrap
   assign rval_tmo_eff = (cfg_rval_tmo == '0) ? TWIDTH'(1) : cfg_rval_tmo;
   assign age          = now - head_ts;
   assign forced       = ~fifo_empty & (age >= rval_tmo_eff) & ~m_rval;
   assign pop          = ~fifo_empty & (m_rval | forced);
   assign odd_rval     = m_rval & fifo_empty;

   // The release cycle itself is not counted so the next transaction starts fresh
   assign busy_cycle   = (m_wreq | m_rreq) & m_busy & ~rel_q;
   assign busy_cnt_inc = {1'b0, busy_cnt} + 1'b1;
   assign busy_hit     = busy_cycle & (cfg_busy_tmo != '0) & (busy_cnt_inc >= {1'b0, cfg_busy_tmo});
   assign fault_inc    = {1'b0, busy_hit} + {1'b0, forced};

   mmv_guard_fifo #(
      .DEPTH (MAXPENDRD),
      .WIDTH (TWIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (now),
      .pop       (pop),
      .head_data (head_ts),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Timestamp, busy release, upstream read response, status pulses and fault count
   always_ff @(posedge clk) begin
      if (rst) begin
         now          <= '0;
         busy_cnt     <= '0;
         rel_q        <= 1'b0;
         s_rval       <= 1'b0;
         s_rdat       <= '0;
         busy_timeout <= 1'b0;
         rval_timeout <= 1'b0;
         rval_is_odd  <= 1'b0;
         fault_cnt    <= '0;
      end else begin
         now          <= now + 1'b1;
         busy_cnt     <= (busy_cycle & ~busy_hit) ? busy_cnt_inc[TWIDTH-1:0] : '0;
         rel_q        <= busy_hit;
         busy_timeout <= busy_hit;
         rval_timeout <= forced;
         rval_is_odd  <= odd_rval;
         s_rval       <= pop | iso_rd;
         if (pop | iso_rd) s_rdat <= (pop & m_rval) ? m_rdat : ERRRDVAL;
         fault_cnt    <= clr ? '0 : sat_add(fault_cnt, fault_inc);
      end
   end

`ifdef MMV_GUARD_ISOLATE_EN
   localparam logic [FAULT_W-1:0] ISO_LIM = FAULT_W'(ISOLTHR);

   guard_state_t       state;
   logic [FAULT_W-1:0] consec;
   logic [FAULT_W-1:0] consec_nxt;
   logic               isolated_q;
   logic               rd_ok;
   logic               wr_ok;

   assign fwd_en   = (state == ST_NORMAL);
   assign drain    = (state == ST_DRAIN);
   assign iso      = (state == ST_ISOLATED);
   assign isolated = isolated_q;

   // A good completion breaks the run of consecutive faults
   assign rd_ok = pop & m_rval;
   assign wr_ok = s_wreq & ~s_busy & fwd_en & ~rel_q;

   // Consecutive-fault tally; faults in the same cycle take precedence over a good completion
   always_comb begin
      consec_nxt = consec;
      if (fault_inc != 2'd0)    consec_nxt = sat_add(consec, fault_inc);
      else if (rd_ok | wr_ok)   consec_nxt = '0;
   end

   // Isolation FSM: stop forwarding, drain outstanding reads, then answer locally
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state      <= ST_NORMAL;
         consec     <= '0;
         isolated_q <= 1'b0;
      end else begin
         consec <= consec_nxt;
         case (state)
            ST_NORMAL: begin
               if (consec_nxt >= ISO_LIM) begin
                  state      <= ST_DRAIN;
                  isolated_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty) state <= ST_ISOLATED;
               isolated_q <= 1'b1;
            end
            ST_ISOLATED: isolated_q <= 1'b1;
            default: begin
               state      <= ST_NORMAL;
               isolated_q <= 1'b0;
            end
         endcase
      end
   end
`else
   logic unused_isolthr;

   assign fwd_en         = 1'b1;
   assign drain          = 1'b0;
   assign iso            = 1'b0;
   assign isolated       = 1'b0;
   assign unused_isolthr = (ISOLTHR != 0);
`endif

endmodule

// File: tb/tb_mmv_guard.sv
// tb/tb_mmv_guard.sv - directed and randomized checks of mmv_guard against a queue-based reference model
module tb_mmv_guard;

   localparam int DEPTH   = 8;
   localparam int ISO_THR = 2;
`ifdef MMV_GUARD_ISOLATE_EN
   localparam bit ISO_EN = 1'b1;
`else
   localparam bit ISO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_addr, s_wdat, s_rdat, m_addr, m_wdat, m_rdat;
   logic        s_wreq, s_rreq, s_rval, s_busy;
   logic        m_wreq, m_rreq, m_rval, m_busy;
   logic [7:0]  cfg_busy_tmo, cfg_rval_tmo;
   logic        clr, busy_timeout, rval_timeout, rval_is_odd, isolated;
   logic [15:0] fault_cnt;

   mmv_guard #(.ISOLTHR(ISO_THR)) dut (
      .clk(clk), .rst(rst),
      .s_addr(s_addr), .s_wreq(s_wreq), .s_wdat(s_wdat), .s_rreq(s_rreq),
      .s_rdat(s_rdat), .s_rval(s_rval), .s_busy(s_busy),
      .m_addr(m_addr), .m_wreq(m_wreq), .m_wdat(m_wdat), .m_rreq(m_rreq),
      .m_rdat(m_rdat), .m_rval(m_rval), .m_busy(m_busy),
      .cfg_busy_tmo(cfg_busy_tmo), .cfg_rval_tmo(cfg_rval_tmo), .clr(clr),
      .busy_timeout(busy_timeout), .rval_timeout(rval_timeout),
      .rval_is_odd(rval_is_odd), .fault_cnt(fault_cnt), .isolated(isolated)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending reads are the absolute cycle numbers they were accepted in
   int         pend[$];
   int         cyc = 0;
   int         busy_run, st, consec, e_fault;
   bit         rel, e_rval, e_btmo, e_rtmo, e_odd;
   logic [7:0] e_rdat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_regs();
      chk("s_rval", s_rval, e_rval);
      chk("s_rdat", s_rdat, e_rdat);
      chk("busy_timeout", busy_timeout, e_btmo);
      chk("rval_timeout", rval_timeout, e_rtmo);
      chk("rval_is_odd", rval_is_odd, e_odd);
      chk("fault_cnt", fault_cnt, e_fault);
      chk("isolated", isolated, (st != 0));
   endtask

   task automatic model_reset();
      pend.delete();
      busy_run = 0; st = 0; consec = 0; e_fault = 0; rel = 1'b0;
      e_rval = 1'b0; e_btmo = 1'b0; e_rtmo = 1'b0; e_odd = 1'b0; e_rdat = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1; s_wreq = 1'b0; s_rreq = 1'b0; m_busy = 1'b0; m_rval = 1'b0;
      m_rdat = 8'h00; clr = 1'b0; s_addr = 8'h00; s_wdat = 8'h00;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      chk_regs();
   endtask

   // One clock cycle: drive inputs, check combinational outputs at negedge, advance model, check registers
   task automatic step(input bit wr, input bit rd, input bit mb, input bit mv,
                       input logic [7:0] md, input bit cl);
      bit         full, fwd, drn, iso, x_sbusy, x_mw, x_mr, nonempty;
      bit         forced, pop, odd, bcyc, hit, iso_rd, rd_ok, wr_ok;
      int         tmo, nf;
      logic [7:0] a, d;
      a = 8'($urandom); d = 8'($urandom);
      s_addr = a; s_wdat = d; s_wreq = wr; s_rreq = rd;
      m_busy = mb; m_rval = mv; m_rdat = md; clr = cl;
      @(negedge clk);
      full    = (pend.size() >= DEPTH);
      fwd     = (st == 0); drn = (st == 1); iso = (st == 2);
      x_sbusy = drn | (fwd & ((mb & ~rel) | full));
      x_mw    = wr & ~full & fwd;
      x_mr    = rd & ~full & fwd;
      chk("m_addr", m_addr, a);
      chk("m_wdat", m_wdat, d);
      chk("s_busy", s_busy, x_sbusy);
      chk("m_wreq", m_wreq, x_mw);
      chk("m_rreq", m_rreq, x_mr);
      tmo      = (cfg_rval_tmo == 8'd0) ? 1 : int'(cfg_rval_tmo);
      nonempty = (pend.size() > 0);
      forced   = nonempty && ((cyc - pend[0]) >= tmo) && !mv;
      pop      = nonempty && (mv || forced);
      odd      = mv && !nonempty;
      bcyc     = (x_mw || x_mr) && mb && !rel;
      hit      = bcyc && (cfg_busy_tmo != 8'd0) && ((busy_run + 1) >= int'(cfg_busy_tmo));
      iso_rd   = iso && rd;
      rd_ok    = pop && mv;
      wr_ok    = wr && !x_sbusy && fwd && !rel;
      nf       = int'(hit) + int'(forced);
      if (pop) void'(pend.pop_front());
      if (fwd && rd && !x_sbusy) pend.push_back(cyc);
      busy_run = (bcyc && !hit) ? busy_run + 1 : 0;
      rel      = hit;
      e_btmo   = hit; e_rtmo = forced; e_odd = odd;
      e_rval   = pop || iso_rd;
      if (pop)         e_rdat = mv ? md : 8'hFF;
      else if (iso_rd) e_rdat = 8'hFF;
      e_fault  = cl ? 0 : (((e_fault + nf) > 65535) ? 65535 : e_fault + nf);
      if (ISO_EN) begin
         if (cl) begin
            st = 0; consec = 0;
         end else begin
            if (nf > 0)              consec += nf;
            else if (rd_ok || wr_ok) consec = 0;
            if (st == 0 && consec >= ISO_THR) st = 1;
            else if (st == 1 && !nonempty)    st = 2;
         end
      end
      cyc++;
      @(posedge clk); #1;
      chk_regs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      cfg_busy_tmo = 8'd0;
      cfg_rval_tmo = 8'd10;
      do_reset();
      // s_busy follows m_busy straight after reset
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

      // Read answered 3 cycles later with 0x5A
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(2);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
      chk("t1_rdat", s_rdat, 8'h5A);
      idle(2);

      // Unanswered read with a 5-cycle deadline
      cfg_rval_tmo = 8'd5;
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(7);
      chk("t2_faults", fault_cnt, 16'd1);

      // Write stuck behind m_busy with a 4-cycle busy limit
      cfg_busy_tmo = 8'd4;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      idle(2);
      cfg_busy_tmo = 8'd0;

      // Fill all pending slots, ninth read held off until an m_rval frees one
      cfg_rval_tmo = 8'd200;
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0);

      // m_rval with nothing pending
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
      idle(1);

      // Reset with a read outstanding; the late answer must be odd
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      do_reset();
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
      idle(1);

      // Two read timeouts in a row, then a read, then clr
      cfg_rval_tmo = 8'd3;
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(4);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      idle(4);
      chk("iso_after_two", isolated, ISO_EN);
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1);
      chk("iso_after_clr", isolated, 1'b0);
      idle(6);

      // Randomized traffic under a few configurations
      for (int r = 0; r < 4; r++) begin
         do_reset();
         cfg_rval_tmo = 8'($urandom_range(0, 12));
         cfg_busy_tmo = 8'($urandom_range(0, 6));
         for (int i = 0; i < 300; i++)
            step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 3) == 0,
                 ($urandom % 6) == 0, 8'($urandom), ($urandom % 60) == 0);
         idle(20);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
